// File: rtl/fc_tile_sequencer_if.sv
// Command, handshake and status bundle between the NPU top control, the FC tile sequencer
// and the downstream AGU / PE array.
interface fc_tile_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 8
);
    logic              i_LayerStart;
    logic              i_Abort;
    logic [ADDR_W-1:0] i_StartAdder;
    logic [ADDR_W-1:0] i_TileStride;
    logic [CNT_W-1:0]  i_Input_PieceNum;
    logic [CNT_W-1:0]  i_Out_PieceNum;
    logic [CNT_W-1:0]  i_TileNum;
    logic              i_PreComp_Rdy;
    logic              i_PE_Rdy;

    logic              o_AGUStart;
    logic [ADDR_W-1:0] o_StartAdder;
    logic              o_bFirstTiling;
    logic              o_bLastTiling;
    logic              o_GroupStart;
    logic [CNT_W-1:0]  o_TileIdx;
    logic              o_Busy;
    logic              o_LayerDone;

    modport master (
        output i_LayerStart, i_Abort, i_StartAdder, i_TileStride,
               i_Input_PieceNum, i_Out_PieceNum, i_TileNum, i_PreComp_Rdy, i_PE_Rdy,
        input  o_AGUStart, o_StartAdder, o_bFirstTiling, o_bLastTiling,
               o_GroupStart, o_TileIdx, o_Busy, o_LayerDone
    );

    modport slave (
        input  i_LayerStart, i_Abort, i_StartAdder, i_TileStride,
               i_Input_PieceNum, i_Out_PieceNum, i_TileNum, i_PreComp_Rdy, i_PE_Rdy,
        output o_AGUStart, o_StartAdder, o_bFirstTiling, o_bLastTiling,
               o_GroupStart, o_TileIdx, o_Busy, o_LayerDone
    );
endinterface

// File: rtl/fc_tile_sequencer.sv
// FC layer tile sequencer: splits one layer command into tilings, starts the AGU per tiling
// and paces one group-start per IOB read, throttled by PE and AGU readiness.
module fc_tile_sequencer #(
    parameter int ADDR_W    = 12,
    parameter int CNT_W     = 8,
    parameter int GROUP_GAP = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    fc_tile_sequencer_if.slave bus
);
    localparam int GAP_W = 4;
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [GAP_W-1:0]  GAP_ZERO  = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GROUP_GAP > 32'sd0) ? (GROUP_GAP - 32'sd1) : 32'sd0);
    localparam bit                NO_GAP    = (GROUP_GAP == 32'sd0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ARM   = 3'd2,
        ISSUE = 3'd3,
        GAP   = 3'd4,
        TEND  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  inNum;
    logic [CNT_W-1:0]  outNum;
    logic [CNT_W-1:0]  tileNum;
    logic [CNT_W-1:0]  inCnt;
    logic [CNT_W-1:0]  outCnt;
    logic [CNT_W-1:0]  tileIdx;
    logic [ADDR_W-1:0] tileStride;
    logic [ADDR_W-1:0] startAdder;
    logic [GAP_W-1:0]  gapCnt;
    logic              aguStart;
    logic              layerDone;
    logic              busy;

    logic groupFire;
    logic inWrap;
    logic outWrap;
    logic lastTile;

    // A count of 0 reads as 256: (cnt+1) wraps to 0 in CNT_W bits exactly at the 256th step.
    always_comb begin
        groupFire = (state == ISSUE) && bus.i_PE_Rdy && bus.i_PreComp_Rdy
                    && !bus.i_Abort && !i_rst;
        inWrap    = ((inCnt + CNT_ONE) == inNum);
        outWrap   = ((outCnt + CNT_ONE) == outNum);
        lastTile  = ((tileIdx + CNT_ONE) == tileNum);
    end

    // Layer FSM with its registered pulses, counters and per-tiling address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            inNum      <= CNT_ZERO;
            outNum     <= CNT_ZERO;
            tileNum    <= CNT_ZERO;
            inCnt      <= CNT_ZERO;
            outCnt     <= CNT_ZERO;
            tileIdx    <= CNT_ZERO;
            tileStride <= ADDR_ZERO;
            startAdder <= ADDR_ZERO;
            gapCnt     <= GAP_ZERO;
            aguStart   <= 1'b0;
            layerDone  <= 1'b0;
            busy       <= 1'b0;
        end else if (bus.i_Abort) begin
            state     <= IDLE;
            aguStart  <= 1'b0;
            layerDone <= 1'b0;
            busy      <= 1'b0;
        end else begin
            aguStart  <= 1'b0;
            layerDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_LayerStart) begin
                        inNum      <= bus.i_Input_PieceNum;
                        outNum     <= bus.i_Out_PieceNum;
                        tileNum    <= bus.i_TileNum;
                        tileStride <= bus.i_TileStride;
                        startAdder <= bus.i_StartAdder;
                        tileIdx    <= CNT_ZERO;
                        busy       <= 1'b1;
                        aguStart   <= 1'b1;
                        state      <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    inCnt  <= CNT_ZERO;
                    outCnt <= CNT_ZERO;
                    state  <= ARM;
                end
                ARM: begin
                    if (bus.i_PreComp_Rdy) begin
                        state <= ISSUE;
                    end else begin
                        state <= ARM;
                    end
                end
                ISSUE: begin
                    if (groupFire) begin
                        gapCnt <= GAP_ZERO;
                        if (inWrap) begin
                            inCnt  <= CNT_ZERO;
                            outCnt <= outWrap ? CNT_ZERO : (outCnt + CNT_ONE);
                        end else begin
                            inCnt <= inCnt + CNT_ONE;
                        end
                        if (inWrap && outWrap) begin
                            state <= TEND;
                        end else if (NO_GAP) begin
                            state <= ISSUE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        state <= ISSUE;
                    end
                end
                GAP: begin
                    if (gapCnt == GAP_LAST) begin
                        state <= ISSUE;
                    end else begin
                        gapCnt <= gapCnt + GAP_ONE;
                    end
                end
                TEND: begin
                    if (lastTile) begin
                        layerDone <= 1'b1;
                        state     <= DONE;
                    end else begin
                        // Address wraps silently at 2^ADDR_W.
                        tileIdx    <= tileIdx + CNT_ONE;
                        startAdder <= startAdder + tileStride;
                        aguStart   <= 1'b1;
                        state      <= START;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_AGUStart     = aguStart;
    assign bus.o_StartAdder   = startAdder;
    assign bus.o_TileIdx      = tileIdx;
    assign bus.o_Busy         = busy;
    assign bus.o_LayerDone    = layerDone;
    assign bus.o_GroupStart   = groupFire;
    assign bus.o_bFirstTiling = busy && (tileIdx == CNT_ZERO);
    assign bus.o_bLastTiling  = busy && lastTile;
endmodule

// File: tb/tb_fc_tile_sequencer.sv
// Scoreboard bench for fc_tile_sequencer: stimulus pushes expected pulse events,
// a negedge monitor pops and compares each AGUStart / GroupStart / LayerDone.
module tb_fc_tile_sequencer;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic [1:0]  kind;
        logic [11:0] addr;
        logic        first;
        logic        last;
        logic [7:0]  idx;
    } ev_t;

    localparam logic [1:0] K_AGU  = 2'd0;
    localparam logic [1:0] K_GRP  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nChecks = 0;
    int   nPass = 0;
    int   grpCount = 0;
    int   startCyc = 0;
    int   aguCyc = 0;
    int   firstGrpCyc = 0;
    int   doneCyc = 0;
    int   prevGrpCyc = -1;
    bit   firstPending = 1'b0;
    bit   peAlways = 1'b1;
    ev_t  expQ[$];

    fc_tile_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    fc_tile_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .GROUP_GAP(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic monitor_step();
        int  n;
        ev_t act;
        ev_t e;
        n = int'(bus.o_AGUStart) + int'(bus.o_GroupStart) + int'(bus.o_LayerDone);
        if (n > 1) begin
            check("single_pulse", n, 32'd1);
        end else if (n == 1) begin
            act.kind  = bus.o_AGUStart ? K_AGU : (bus.o_GroupStart ? K_GRP : K_DONE);
            act.addr  = bus.o_StartAdder;
            act.first = bus.o_bFirstTiling;
            act.last  = bus.o_bLastTiling;
            act.idx   = bus.o_TileIdx;
            if (expQ.size() == 0) begin
                nChecks++;
                $display("FAIL unexpected_event: got 0x%0h expected none (cycle %0d)", act, cyc);
            end else begin
                e = expQ.pop_front();
                check("event", act, e);
            end
            if (act.kind == K_AGU) begin
                aguCyc       = cyc;
                firstPending = 1'b1;
                prevGrpCyc   = -1;
            end else if (act.kind == K_GRP) begin
                grpCount++;
                if (firstPending) begin
                    firstGrpCyc  = cyc;
                    firstPending = 1'b0;
                end
                check("pe_gate", bus.i_PE_Rdy, 32'd1);
                if (prevGrpCyc >= 0) begin
                    if (peAlways) check("spacing", cyc - prevGrpCyc, 32'd2);
                    else          check("spacing_min", 32'((cyc - prevGrpCyc) >= 2), 32'd1);
                end
                prevGrpCyc = cyc;
            end else begin
                doneCyc = cyc;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) monitor_step();
        end
    end

    task automatic push_layer(input logic [11:0] st, input logic [11:0] sd,
                              input int nin, input int nout, input int nt);
        ev_t e;
        logic [11:0] a;
        int gi, go, ntt;
        gi  = (nin == 0) ? 256 : nin;
        go  = (nout == 0) ? 256 : nout;
        ntt = (nt == 0) ? 256 : nt;
        a   = st;
        for (int t = 0; t < ntt; t++) begin
            e.kind  = K_AGU;
            e.addr  = a;
            e.first = (t == 0);
            e.last  = (t == ntt - 1);
            e.idx   = 8'(t);
            expQ.push_back(e);
            e.kind = K_GRP;
            for (int g = 0; g < gi * go; g++) expQ.push_back(e);
            if (t != ntt - 1) a = a + sd;
        end
        e.kind = K_DONE;
        expQ.push_back(e);
    endtask

    task automatic issue_start(input logic [11:0] st, input logic [11:0] sd,
                               input int nin, input int nout, input int nt);
        bus.i_StartAdder     = st;
        bus.i_TileStride     = sd;
        bus.i_Input_PieceNum = 8'(nin);
        bus.i_Out_PieceNum   = 8'(nout);
        bus.i_TileNum        = 8'(nt);
        bus.i_LayerStart     = 1'b1;
        startCyc             = cyc;
        @(posedge clk); #1;
        bus.i_LayerStart = 1'b0;
    endtask

    task automatic wait_idle(input string name, input bit rnd);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (expQ.size() == 0 && !bus.o_Busy) begin
                ok = 1'b1;
                break;
            end
            if (rnd) bus.i_PE_Rdy = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.i_PE_Rdy = 1'b1;
        check({name, "_complete"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_groups(input string name, input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (grpCount >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({name, "_reached"}, 32'(ok), 32'd1);
    endtask

    task automatic run_layer(input string name, input logic [11:0] st, input logic [11:0] sd,
                             input int nin, input int nout, input int nt,
                             input bit rnd, input int expGroups);
        push_layer(st, sd, nin, nout, nt);
        grpCount = 0;
        peAlways = !rnd;
        issue_start(st, sd, nin, nout, nt);
        wait_idle(name, rnd);
        check({name, "_groups"}, grpCount, expGroups);
    endtask

    task automatic check_idle(input string name);
        check(name, {bus.o_AGUStart, bus.o_GroupStart, bus.o_LayerDone, bus.o_Busy,
                     bus.o_bFirstTiling, bus.o_bLastTiling, bus.o_StartAdder, bus.o_TileIdx},
              32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.i_LayerStart     = 1'b0;
        bus.i_Abort          = 1'b0;
        bus.i_StartAdder     = 12'h000;
        bus.i_TileStride     = 12'h000;
        bus.i_Input_PieceNum = 8'd0;
        bus.i_Out_PieceNum   = 8'd0;
        bus.i_TileNum        = 8'd0;
        bus.i_PreComp_Rdy    = 1'b1;
        bus.i_PE_Rdy         = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset_outputs");

        // T1: single tiling, 2x3 groups, latency and spacing
        run_layer("T1", 12'h010, 12'h000, 2, 3, 1, 1'b0, 6);
        check("T1_agu_latency", aguCyc - startCyc, 32'd1);
        check("T1_first_group_latency", firstGrpCyc - startCyc, 32'd3);
        check("T1_done_latency", doneCyc - startCyc, 32'd15);
        check("T1_busy_low", bus.o_Busy, 32'd0);

        // T2: three tilings, address wraps 0xFC0 -> 0x000 -> 0x040
        run_layer("T2", 12'hFC0, 12'h040, 1, 2, 3, 1'b0, 6);

        // T3: PE readiness toggled pseudo-randomly
        run_layer("T3", 12'h100, 12'h010, 3, 2, 2, 1'b1, 12);

        // T4: input piece count 0 means 256
        run_layer("T4", 12'h000, 12'h000, 0, 1, 1, 1'b0, 256);

        // T5: abort after the 4th group, then rerun T1
        push_layer(12'h010, 12'h000, 2, 3, 1);
        grpCount = 0;
        peAlways = 1'b1;
        issue_start(12'h010, 12'h000, 2, 3, 1);
        wait_groups("T5_groups4", 4);
        bus.i_Abort = 1'b1;
        expQ.delete();
        @(posedge clk); #1;
        bus.i_Abort = 1'b0;
        check("T5_busy_after_abort", bus.o_Busy, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("T5_groups_after_abort", grpCount, 32'd4);
        // abort and LayerStart together: stay idle
        bus.i_Abort      = 1'b1;
        bus.i_LayerStart = 1'b1;
        @(posedge clk); #1;
        bus.i_Abort      = 1'b0;
        bus.i_LayerStart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("T5_abort_and_start_idle", bus.o_Busy, 32'd0);
        run_layer("T5_rerun", 12'h010, 12'h000, 2, 3, 1, 1'b0, 6);

        // T6: LayerStart re-pulsed mid-layer is ignored, then reset mid-tiling
        push_layer(12'h200, 12'h020, 2, 2, 2);
        grpCount = 0;
        peAlways = 1'b1;
        issue_start(12'h200, 12'h020, 2, 2, 2);
        wait_groups("T6_groups2", 2);
        bus.i_StartAdder     = 12'h777;
        bus.i_Input_PieceNum = 8'd5;
        bus.i_TileNum        = 8'd1;
        bus.i_LayerStart     = 1'b1;
        @(posedge clk); #1;
        bus.i_LayerStart = 1'b0;
        wait_groups("T6_groups6", 6);
        rst = 1'b1;
        expQ.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("T6_outputs_after_reset");
        repeat (5) @(posedge clk);
        #1;
        check("T6_groups_after_reset", grpCount, 32'd6);
        run_layer("T6_rerun", 12'h010, 12'h000, 2, 3, 1, 1'b0, 6);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
